// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is stepped LSB first
// across WIDTH-bit operands, with valid/ready handshakes on request and result.

module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_b & i_c) | (i_c & i_a);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_bit;
  logic             w_carry_nxt;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum_nxt;

  serial_fa_cell u_fa (
    .i_a (r_a_sr[0]),
    .i_b (r_b_sr[0]),
    .i_c (r_carry),
    .o_s (w_bit),
    .o_c (w_carry_nxt)
  );

  // The new bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign w_sum_nxt = {w_bit, r_sum_sr[WIDTH-1:1]};
  assign in_ready  = (r_state == IDLE) && rst_n;
  assign w_accept  = in_valid && in_ready;

  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values; a blocking = would let later statements see updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_sum_sr    <= '0;
      r_carry     <= 1'b0;
      r_bit_cnt   <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Subtract is A + ~B + 1: invert B and force the carry-in.
            r_a_sr    <= a;
            r_b_sr    <= sub ? ~b : b;
            r_carry   <= sub ? 1'b1 : cin;
            r_sum_sr  <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end
        end

        RUN: begin
          r_carry  <= w_carry_nxt;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_sum_sr <= w_sum_nxt;
          if (r_bit_cnt == LAST_BIT) begin
            // r_carry is the carry into the MSB, w_carry_nxt the carry out of it.
            r_sum       <= w_sum_nxt;
            r_cout      <= w_carry_nxt;
            r_ovf       <= r_carry ^ w_carry_nxt;
            r_out_valid <= 1'b1;
            r_bit_cnt   <= '0;
            r_state     <= DONE;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed and random operations
// compared against an integer-arithmetic reference model.

module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    exp_t   e;
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      ur   = ua - ub;
      sr   = sa - sb;
      e.co = (ua >= ub);
    end else begin
      ur   = ua + ub + longint'(mcin);
      sr   = sa + sb + longint'(mcin);
      e.co = (ur >= (longint'(1) << W));
    end
    e.s  = ur[W-1:0];
    e.ov = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and clocks it in; returns how many cycles in_ready was awaited.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub, output int waited);
    a        = ta;
    b        = tb;
    cin      = tcin;
    sub      = tsub;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 40) begin
      tick();
      waited++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Follows the operation through RUN into DONE, checking latency and result.
  task automatic finish_op(input string tag, input exp_t e);
    for (int k = 1; k <= W; k++) begin
      if (k < W) begin
        check({tag, "_run_flags"}, 32'({out_valid, in_ready, busy}), 32'b001);
        tick();
      end else begin
        check({tag, "_done_flags"}, 32'({out_valid, in_ready, busy}), 32'b101);
      end
    end
    check({tag, "_sum"}, 32'(sum), 32'(e.s));
    check({tag, "_cout"}, 32'(cout), 32'(e.co));
    check({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_flags"}, 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
    int w;
    start_op(ta, tb, tcin, tsub, w);
    tick();
    finish_op(tag, model(ta, tb, tcin, tsub));
    consume(tag);
  endtask

  initial begin
    exp_t         e;
    exp_t         q[$];
    int           w;
    int           cyc;
    int           last_acc;
    int           n_acc;
    int           n_res;
    logic         acc;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outs", 32'({out_valid, busy, cout, ovf}), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Directed arithmetic cases
    run_op("add_100_27", 8'd100, 8'd27, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add_7f_cin", 8'h7F, 8'h00, 1'b1, 1'b0);
    run_op("sub_5_7", 8'd5, 8'd7, 1'b1, 1'b1);
    run_op("sub_80_1", 8'h80, 8'd1, 1'b0, 1'b1);
    run_op("sub_eq", 8'h5A, 8'h5A, 1'b0, 1'b1);
    run_op("add_ff_ff_cin", 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Random single operations
    for (int i = 0; i < 8; i++) begin
      run_op("rand_op", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    // Backpressure: hold DONE for 5 cycles while a new request waits
    e = model(8'h9C, 8'h33, 1'b1, 1'b0);
    start_op(8'h9C, 8'h33, 1'b1, 1'b0, w);
    tick();
    finish_op("bp_first", e);
    a        = 8'h12;
    b        = 8'h34;
    cin      = 1'b0;
    sub      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_sum", 32'(sum), 32'(e.s));
      check("bp_hold_flags", 32'({out_valid, in_ready, cout, ovf}), 32'({1'b1, 1'b0, e.co, e.ov}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", 32'({out_valid, in_ready, busy}), 32'b010);
    start_op(8'h12, 8'h34, 1'b0, 1'b1, w);
    check("bp_accept_wait", 32'(w), 32'd0);
    check("bp_accepted", 32'({in_ready, busy}), 32'b01);
    tick();
    finish_op("bp_second", model(8'h12, 8'h34, 1'b0, 1'b1));
    consume("bp_second");

    // Reset during the 4th RUN cycle
    start_op(8'hAA, 8'h55, 1'b0, 1'b0, w);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_outs", 32'({out_valid, busy, cout, ovf}), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    n_res = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (out_valid) n_res++;
    end
    check("mid_rst_no_output", 32'(n_res), 32'd0);
    run_op("post_rst_3_4", 8'd3, 8'd4, 1'b0, 1'b0);

    // Back-to-back with in_valid held high and out_ready high
    last_acc  = -1;
    n_acc     = 0;
    n_res     = 0;
    a         = W'($urandom);
    b         = W'($urandom);
    cin       = 1'($urandom);
    sub       = 1'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (cyc = 0; cyc < 8 * (W + 2); cyc++) begin
      if (cyc == 6 * (W + 2)) in_valid = 1'b0;
      acc = in_valid && in_ready;
      ra  = a;
      rb  = b;
      rc  = cin;
      rs  = sub;
      tick();
      if (acc) begin
        if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
        n_acc++;
        q.push_back(model(ra, rb, rc, rs));
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
      end
      if (out_valid) begin
        n_res++;
        if (q.size() == 0) begin
          check("b2b_spurious", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("b2b_sum", 32'(sum), 32'(e.s));
          check("b2b_cout_ovf", 32'({cout, ovf}), 32'({e.co, e.ov}));
        end
      end
    end
    out_ready = 1'b0;
    check("b2b_accept_count", 32'(n_acc), 32'd6);
    check("b2b_result_count", 32'(n_res), 32'(n_acc));
    check("b2b_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add/subtract controller that sequences one full-adder cell over WIDTH-bit operands, LSB first, one bit per clock. The bit cell is instantiated inside this block. It accepts an operation on a valid/ready input handshake and returns the WIDTH-bit result, carry-out and signed overflow on a valid/ready output handshake. It serves as the small-area arithmetic unit for slow control paths where a parallel WIDTH-bit adder is not justified.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
in_valid  input  1  operation request.
in_ready  output  1  block can accept; equals (state==IDLE) && rst_n.
a  input  WIDTH  operand A, sampled at acceptance.
b  input  WIDTH  operand B, sampled at acceptance.
cin  input  1  carry-in for add; ignored for subtract.
sub  input  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1.
out_valid  output  1  result available (registered).
out_ready  input  1  consumer takes result.
sum  output  WIDTH  result, registered, held while out_valid.
cout  output  1  final carry; for subtract, 1 = no borrow.
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: when rst_n=0 at a rising edge, state becomes IDLE and sum, cout, ovf, out_valid, busy, the bit counter and the internal shift and carry registers all become 0. in_ready is 0 while rst_n=0 and 1 from the first cycle after reset is released. Reset during RUN or DONE abandons the operation and produces no output.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - An edge with in_valid && in_ready is the acceptance.
  - On acceptance: load a_sr<=a, load b_sr<=(sub ? ~b : b), set carry<=(sub ? 1 : cin), clear bit_cnt, go to RUN.
  - in_valid with in_ready=0 is ignored. The requester must hold a, b, cin and sub stable until acceptance.
- RUN, each edge:
  - bit = a_sr[0]^b_sr[0]^carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - sum_sr shifts right with bit entering the MSB.
  - a_sr and b_sr shift right.
  - bit_cnt increments.
  - On the edge that processes bit WIDTH-1: capture the carry into bit WIDTH-1, set cout to the new carry, compute ovf, present sum, set out_valid<=1, go to DONE.
- Latency: out_valid rises exactly WIDTH cycles after the acceptance edge. Minimum initiation interval is WIDTH+2 cycles (IDLE→RUN→DONE→IDLE).
- DONE:
  - sum, cout, ovf and out_valid hold stable until an edge with out_ready=1.
  - On that edge: out_valid<=0, go to IDLE.
  - sum, cout and ovf keep their last values in IDLE; they are valid only when out_valid=1.
- out_ready while not in DONE has no effect. in_valid in RUN or DONE is not accepted, because in_ready=0.
- Arithmetic wraps modulo 2^WIDTH. Results are bit-exact to the parallel equations: sum=A^B^C, carry=AB|BC|CA.
- bit_cnt is $clog2(WIDTH) bits wide and never wraps mid-operation.

Test Plan:
- Add, WIDTH=8: a=100, b=27, cin=0, sub=0 → sum=127, cout=0, ovf=0; out_valid rises 8 cycles after acceptance; in_ready=0 for those 8 cycles and the DONE cycle.
- Carry and overflow:
  - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0.
  - a=8'h7F, b=8'h00, cin=1 → sum=8'h80, cout=0, ovf=1.
- Subtract:
  - a=5, b=7, sub=1, cin=1 → sum=8'hFE, cout=0, ovf=0; cin is ignored.
  - a=8'h80, b=1, sub=1 → sum=8'h7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid meanwhile → sum, cout and ovf stay constant; the new request is not accepted until the cycle after the out_ready handshake returns the block to IDLE.
- Reset: drop rst_n for 1 cycle during the 4th RUN cycle → next cycle IDLE, all outputs 0, no out_valid pulse; a following request a=3, b=4 → sum=7.
- Back-to-back requests with in_valid held high and out_ready=1 → accepts every WIDTH+2 cycles; each result matches a reference model.
